// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, word fetches to imem, 2-entry instruction buffer to decode.
// Latency: request accepted at T, response at T+k (k>=1), instr_valid at T+k+1 (no bypass).
// Backpressure: decode_ready low holds the buffer head; requests stop once in-flight+buffered reach 2.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt     fetch request channel (word address, granted when req & gnt)
//   imem_rvalid/imem_rdata          in-order fetch responses
//   redirect/redirect_target        flush and restart fetching at the (word-aligned) target
//   instr_valid/decode_ready        head-of-buffer handshake to decode
//   instr/instr_pc/imm16            head instruction, its address, and its low half-word

// Small generic FIFO: registered storage, no same-cycle bypass from write to read.
// Latency: a written entry is visible on rd_dat the cycle after the write.
// Backpressure: wr_rdy drops when full; flush empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       wr_rdy,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign wr_rdy = (count != FULL);
  assign rd_vld = (count != '0);
  assign do_wr  = wr_vld & wr_rdy;
  assign do_rd  = rd_vld & rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read unless count says it was written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [15:0] imm16
);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_ent_t;

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_pc_nxt;
  logic [1:0]  outstanding;
  logic [1:0]  outstanding_nxt;
  logic [1:0]  discard;
  logic [1:0]  discard_nxt;
  logic [1:0]  occ;
  logic [2:0]  budget;
  logic [2:0]  stale_cnt;
  logic [31:0] target_pc;
  logic        pop;
  logic        accept;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        push;
  fetch_ent_t  push_ent;
  fetch_ent_t  head_ent;
  logic        fifo_unused_wr_rdy;
  logic        unused_target_lsbs;

  assign target_pc          = {redirect_target[31:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];

  assign pop = instr_valid & decode_ready;

  // Every accepted fetch, kept or stale, must have a buffer slot reserved before
  // it is issued, so a response is never refused. A pop this cycle frees a slot
  // in time, which is why the request depends combinationally on decode_ready.
  assign budget   = {1'b0, outstanding} + {1'b0, discard} + {1'b0, occ} - {2'b00, pop};
  assign imem_req = ~rst & ~redirect & (budget < 3'd2);
  assign imem_addr = pc;
  assign accept    = imem_req & imem_gnt;

  // Stale responses are always older than kept ones, so drain them first.
  // A response with both counters at zero is a protocol error and is ignored.
  assign rsp_drop = imem_rvalid & (discard != 2'd0);
  assign rsp_keep = imem_rvalid & (discard == 2'd0) & (outstanding != 2'd0);
  assign push     = rsp_keep & ~redirect;
  assign push_ent = '{word: imem_rdata, pc: rsp_pc};

  always_comb begin
    pc_nxt          = pc;
    rsp_pc_nxt      = rsp_pc;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    stale_cnt       = {1'b0, discard} + {1'b0, outstanding};
    if (redirect) begin
      pc_nxt          = target_pc;
      rsp_pc_nxt      = target_pc;
      outstanding_nxt = 2'd0;
      // A response arriving in the redirect cycle is itself one of the stale
      // ones; it is consumed now and must not be counted again.
      if (imem_rvalid && (stale_cnt != 3'd0)) begin
        stale_cnt = stale_cnt - 3'd1;
      end
      discard_nxt = stale_cnt[1:0];
    end else begin
      if (accept) begin
        pc_nxt = pc + 32'd4;
      end
      if (rsp_keep) begin
        rsp_pc_nxt = rsp_pc + 32'd4;
      end
      outstanding_nxt = outstanding + {1'b0, accept} - {1'b0, rsp_keep};
      discard_nxt     = discard - {1'b0, rsp_drop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
    end else begin
      pc          <= pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // Redirect flushes the buffer; a pop in that same cycle has already been
  // seen by decode, so losing the head then is correct.
  fetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (2)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect),
    .wr_vld (push),
    .wr_dat (push_ent),
    .wr_rdy (fifo_unused_wr_rdy),
    .rd_vld (instr_valid),
    .rd_rdy (decode_ready),
    .rd_dat (head_ent),
    .count  (occ)
  );

  // Zero the payload when empty so decode never sees stale storage contents.
  assign instr    = instr_valid ? head_ent.word : 32'd0;
  assign instr_pc = instr_valid ? head_ent.pc   : 32'd0;
  assign imm16    = instr[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, in-order memory model with
// variable latency, directed scenarios with literal checks, then a random tail.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        decode_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [15:0] imm16;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .decode_ready    (decode_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .imm16           (imm16)
  );

  typedef struct { logic [31:0] w; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] a; bit stale; } fl_t;
  typedef struct { int due; logic [31:0] a; } mr_t;

  ent_t        fq[$];     // model instruction buffer
  fl_t         infl[$];   // model fetches accepted, not yet returned
  mr_t         memq[$];   // memory side pending responses
  logic [31:0] deliv[$];  // addresses handed to decode
  logic [31:0] m_pc;

  int n_tests;
  int n_fail;
  int cyc;
  int lat;
  int nv;

  logic        c_rst, c_rdy, c_gnt, c_redir;
  logic [31:0] c_tgt;
  logic        d_req, d_valid;
  logic [31:0] d_addr, d_instr, d_pc;
  logic [15:0] d_imm;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] t;
    t = 32'h2000 + {20'd0, a[13:2]} - 32'h3F;
    return {t[15:0], (a[2] ? 16'h4402 : 16'h8402)};
  endfunction

  function automatic logic [31:0] qget(input int i);
    if (i < deliv.size()) return deliv[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare settled outputs against the
  // model, then advance the model to what the coming rising edge must produce.
  task automatic step();
    logic        e_req, e_pop, e_valid, acc;
    logic [31:0] e_instr, e_pc;
    fl_t         r;
    bit          have_r;
    int          due;
    @(negedge clk);
    rst             = c_rst;
    decode_ready    = c_rdy;
    imem_gnt        = c_gnt;
    redirect        = c_redir;
    redirect_target = c_tgt;
    if (!c_rst && memq.size() > 0 && memq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].a);
      void'(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    e_valid = (fq.size() > 0);
    e_instr = e_valid ? fq[0].w  : 32'd0;
    e_pc    = e_valid ? fq[0].pc : 32'd0;
    e_pop   = e_valid & c_rdy;
    e_req   = !c_rst && !c_redir && ((infl.size() + fq.size() - int'(e_pop)) < 2);
    chk("imem_req",    32'(imem_req),    32'(e_req));
    chk("imem_addr",   imem_addr,        m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instr",       instr,            e_instr);
    chk("instr_pc",    instr_pc,         e_pc);
    chk("imm16",       32'(imm16),       32'(e_instr[15:0]));
    d_req = imem_req; d_addr = imem_addr; d_valid = instr_valid;
    d_instr = instr; d_pc = instr_pc; d_imm = imm16;

    acc    = e_req & c_gnt;
    have_r = 0;
    if (e_pop && !c_rst) deliv.push_back(e_pc);
    if (imem_rvalid && infl.size() > 0) begin
      r = infl.pop_front();
      have_r = 1;
    end
    if (c_rst) begin
      fq.delete();
      infl.delete();
      memq.delete();
      m_pc = RPC;
    end else if (c_redir) begin
      foreach (infl[i]) infl[i].stale = 1;
      fq.delete();
      m_pc = {c_tgt[31:2], 2'b00};
    end else begin
      if (e_pop) void'(fq.pop_front());
      if (have_r && !r.stale) fq.push_back('{w: mem_word(r.a), pc: r.a});
      if (acc) begin
        infl.push_back('{a: m_pc, stale: 1'b0});
        due = cyc + lat;
        if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
        memq.push_back('{due: due, a: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1; nv = 0;
    m_pc = RPC;
    c_rst = 1'b1; c_rdy = 1'b0; c_gnt = 1'b1; c_redir = 1'b0; c_tgt = 32'd0;
    rst = 1'b1; decode_ready = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    imem_rdata = 32'd0; redirect = 1'b0; redirect_target = 32'd0;

    // Reset held two cycles
    step(); step();
    chk("rst_req",   32'(d_req),   32'd0);
    chk("rst_valid", 32'(d_valid), 32'd0);
    chk("rst_instr", d_instr,      32'd0);
    chk("rst_ipc",   d_pc,         32'd0);
    chk("rst_imm",   32'(d_imm),   32'd0);
    chk("rst_addr",  d_addr,       32'h100);

    // Streaming, 1-cycle memory
    c_rst = 1'b0; c_rdy = 1'b1; c_gnt = 1'b1; lat = 1;
    step();
    chk("first_req",  32'(d_req), 32'd1);
    chk("first_addr", d_addr,     32'h100);
    step();
    chk("stream_c1_valid", 32'(d_valid), 32'd0);
    step();
    chk("stream_c2_valid", 32'(d_valid), 32'd1);
    chk("stream_c2_pc",    d_pc,         32'h100);
    chk("stream_c2_instr", d_instr,      32'h2001_8402);
    chk("stream_c2_imm",   32'(d_imm),   32'h8402);
    step();
    chk("stream_c3_pc",    d_pc,         32'h104);
    chk("stream_c3_imm",   32'(d_imm),   32'h4402);
    nv = 0;
    repeat (10) begin
      step();
      if (d_valid) nv++;
    end
    chk("stream_rate",    32'(nv), 32'd10);
    chk("stream_last_pc", d_pc,    32'h12C);

    // Reset mid-stream, then backpressure from the first cycle
    c_rst = 1'b1; step();
    c_rst = 1'b0; c_rdy = 1'b0;
    deliv.delete();
    step();
    chk("midrst_valid", 32'(d_valid), 32'd0);
    chk("midrst_addr",  d_addr,       32'h100);
    chk("midrst_req",   32'(d_req),   32'd1);
    for (int i = 1; i < 6; i++) begin
      step();
      if (i >= 2) chk("bp_hold_instr", d_instr, 32'h2001_8402);
    end
    chk("bp_req_drop", 32'(d_req), 32'd0);
    c_rdy = 1'b1;
    repeat (8) step();
    chk("bp_count", 32'(deliv.size()), 32'd8);
    for (int i = 0; i < 4; i++) chk("bp_order", qget(i), 32'h100 + 32'(4 * i));

    // Fill the buffer, then reset with it full
    c_rdy = 1'b0;
    repeat (4) step();
    chk("full_valid", 32'(d_valid), 32'd1);
    chk("full_req",   32'(d_req),   32'd0);
    c_rst = 1'b1; step();
    c_rst = 1'b0;
    step();
    chk("fullrst_valid", 32'(d_valid), 32'd0);
    chk("fullrst_instr", d_instr,      32'd0);
    chk("fullrst_ipc",   d_pc,         32'd0);
    chk("fullrst_addr",  d_addr,       32'h100);

    // Redirect with two fetches in flight, 2-cycle memory
    c_rst = 1'b1; step();
    c_rst = 1'b0; lat = 2; c_rdy = 1'b1; c_gnt = 1'b1;
    deliv.delete();
    step(); step();
    c_redir = 1'b1; c_tgt = 32'h0000_0203;
    step();
    chk("redir_req_low", 32'(d_req), 32'd0);
    c_redir = 1'b0;
    step();
    chk("redir_addr", d_addr,     32'h200);
    chk("redir_req",  32'(d_req), 32'd1);
    repeat (6) step();
    chk("redir_first_pc",  qget(0), 32'h200);
    chk("redir_second_pc", qget(1), 32'h204);

    // Redirect near the top of the address space: PC wraps to zero
    lat = 1;
    c_redir = 1'b1; c_tgt = 32'hFFFF_FFFA;
    step();
    c_redir = 1'b0;
    deliv.delete();
    repeat (10) step();
    chk("wrap_pc0", qget(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", qget(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", qget(2), 32'h0000_0000);
    chk("wrap_pc3", qget(3), 32'h0000_0004);

    // Grant stall
    c_rst = 1'b1; step();
    c_rst = 1'b0; lat = 1; c_gnt = 1'b1; c_rdy = 1'b1;
    deliv.delete();
    step(); step();
    c_gnt = 1'b0;
    repeat (4) begin
      step();
      chk("stall_addr", d_addr,     32'h108);
      chk("stall_req",  32'(d_req), 32'd1);
    end
    c_gnt = 1'b1;
    repeat (6) step();
    chk("stall_resume_pc2", qget(2), 32'h108);
    chk("stall_resume_pc3", qget(3), 32'h10C);

    // Random traffic against the model
    repeat (300) begin
      c_rdy   = ($urandom_range(3) != 0);
      c_gnt   = ($urandom_range(2) != 0);
      lat     = int'($urandom_range(3, 1));
      c_redir = ($urandom_range(15) == 0);
      c_tgt   = $urandom();
      step();
    end
    c_redir = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
